// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, write-FSM state encoding
// and packet length limits.
package router_pkg;

  localparam int LEN_LSB  = 0;
  localparam int LEN_MSB  = 3;
  localparam int DEST_LSB = 4;
  localparam int DEST_MSB = 7;
  localparam int FIELD_W  = 4;

  localparam int DEF_WIDTH = 11;
  localparam int MAX_LEN   = DEF_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DROP
  } wr_state_e;

  // Largest legal payload for an entry of the given byte width.
  function automatic int max_len(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/pkt_write_ctrl_if.sv
// Ingress byte stream, memory write port and packet descriptor bus of one
// router input port.
interface pkt_write_ctrl_if
  import router_pkg::*;
#(
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
);

  logic                 in_valid;
  logic [UWIDTH-1:0]    in_data;
  logic                 in_ready;

  logic                 write_en;
  logic [PTR_SZ-1:0]    waddr;
  logic [PTR_IN_SZ-1:0] waddr_in;
  logic [UWIDTH-1:0]    wdata;

  logic                 pkt_avail;
  logic [PTR_SZ-1:0]    rd_entry;
  logic [PTR_IN_SZ-1:0] rd_len;
  logic [FIELD_W-1:0]   rd_dest;
  logic                 pkt_pop;

  logic                 err;

  modport master (
    output in_valid, in_data, pkt_pop,
    input  in_ready, write_en, waddr, waddr_in, wdata,
           pkt_avail, rd_entry, rd_len, rd_dest, err
  );

  modport slave (
    input  in_valid, in_data, pkt_pop,
    output in_ready, write_en, waddr, waddr_in, wdata,
           pkt_avail, rd_entry, rd_len, rd_dest, err
  );

endinterface

// File: rtl/pkt_write_ctrl_desc_ring.sv
// Per-entry packet descriptor store {len, dest} with the write and read
// entry pointers, both wrapping at DEPTH-1.
module pkt_desc_ring
  import router_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [PTR_IN_SZ-1:0] i_wr_len,
  input  logic [FIELD_W-1:0]   i_wr_dest,
  input  logic                 i_wptr_inc,
  input  logic                 i_rptr_inc,
  output logic [PTR_SZ-1:0]    o_wptr,
  output logic [PTR_SZ-1:0]    o_rptr,
  output logic [PTR_IN_SZ-1:0] o_rd_len,
  output logic [FIELD_W-1:0]   o_rd_dest
);

  typedef struct packed {
    logic [PTR_IN_SZ-1:0] len;
    logic [FIELD_W-1:0]   dest;
  } desc_t;

  desc_t             r_desc [DEPTH];
  logic [PTR_SZ-1:0] r_wptr;
  logic [PTR_SZ-1:0] r_rptr;

  // Explicit wrap so a non-power-of-2 DEPTH never reaches an unused index.
  function automatic logic [PTR_SZ-1:0] ptr_next(input logic [PTR_SZ-1:0] p);
    return (p == PTR_SZ'(DEPTH - 1)) ? '0 : p + PTR_SZ'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is small and rd_len/rd_dest must read 0 in reset,
      // so it is reset like ordinary flops rather than left as a RAM.
      for (int i = 0; i < DEPTH; i++) r_desc[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr_en)    r_desc[r_wptr] <= '{len: i_wr_len, dest: i_wr_dest};
      if (i_wptr_inc) r_wptr <= ptr_next(r_wptr);
      if (i_rptr_inc) r_rptr <= ptr_next(r_rptr);
    end
  end

  assign o_wptr    = r_wptr;
  assign o_rptr    = r_rptr;
  assign o_rd_len  = r_desc[r_rptr].len;
  assign o_rd_dest = r_desc[r_rptr].dest;

endmodule

// File: rtl/pkt_write_ctrl.sv
// Ingress write controller: parses headers, writes each packet into one FIFO
// entry and publishes the oldest complete packet to the reader.
module pkt_write_ctrl
  import router_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input logic             clk,
  input logic             rst_n,
  pkt_write_ctrl_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int MAX_L = max_len(WIDTH);

  wr_state_e            r_state;
  logic [FIELD_W-1:0]   r_cnt;
  logic [PTR_IN_SZ-1:0] r_idx;
  logic [OCC_W-1:0]     r_occ;
  logic [OCC_W-1:0]     r_comp;
  logic                 r_comp_inc;

  logic                 r_write_en;
  logic [PTR_SZ-1:0]    r_waddr;
  logic [PTR_IN_SZ-1:0] r_waddr_in;
  logic [UWIDTH-1:0]    r_wdata;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_hdr_acc;
  logic                 w_hdr_ok;
  logic                 w_reserve;
  logic                 w_cnt_last;
  logic                 w_pkt_done;
  logic                 w_pop;
  logic [FIELD_W-1:0]   w_hdr_len;
  logic [FIELD_W-1:0]   w_hdr_dest;
  logic [PTR_SZ-1:0]    w_wptr;
  logic [PTR_SZ-1:0]    w_rptr;
  logic [PTR_IN_SZ-1:0] w_rd_len;
  logic [FIELD_W-1:0]   w_rd_dest;

  // A full FIFO only blocks new headers; an open packet owns its entry.
  always_comb begin
    // NOTE: default first so no path through the block leaves w_ready
    // unassigned, which would otherwise infer a latch.
    w_ready = 1'b0;
    if (rst_n) w_ready = (r_state == S_IDLE) ? (r_occ < OCC_W'(DEPTH)) : 1'b1;
  end

  assign w_accept   = bus.in_valid && w_ready;
  assign w_hdr_len  = bus.in_data[LEN_MSB:LEN_LSB];
  assign w_hdr_dest = bus.in_data[DEST_MSB:DEST_LSB];
  assign w_hdr_acc  = w_accept && (r_state == S_IDLE);
  assign w_hdr_ok   = (w_hdr_len != '0) && (int'(w_hdr_len) <= MAX_L);
  assign w_reserve  = w_hdr_acc && w_hdr_ok;
  assign w_cnt_last = (r_cnt == FIELD_W'(1));
  assign w_pkt_done = w_accept && (r_state == S_PAYLOAD) && w_cnt_last;
  assign w_pop      = bus.pkt_pop && (r_comp != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_write_en <= 1'b0;
      r_waddr    <= '0;
      r_waddr_in <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      r_write_en <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hdr_acc) begin
            if (w_hdr_ok) begin
              r_state    <= S_PAYLOAD;
              r_cnt      <= w_hdr_len;
              r_idx      <= PTR_IN_SZ'(1);
              r_write_en <= 1'b1;
              r_waddr    <= w_wptr;
              r_waddr_in <= '0;
              r_wdata    <= bus.in_data;
            end else begin
              r_err <= 1'b1;
              if (w_hdr_len != '0) begin
                r_state <= S_DROP;
                r_cnt   <= w_hdr_len;
              end
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_write_en <= 1'b1;
            r_waddr    <= w_wptr;
            r_waddr_in <= r_idx;
            r_wdata    <= bus.in_data;
            r_idx      <= r_idx + PTR_IN_SZ'(1);
            r_cnt      <= r_cnt - FIELD_W'(1);
            if (w_cnt_last) r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (w_accept) begin
            r_cnt <= r_cnt - FIELD_W'(1);
            if (w_cnt_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Completion is published one cycle late so the last byte is in memory first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= '0;
      r_comp     <= '0;
      r_comp_inc <= 1'b0;
    end else begin
      r_comp_inc <= w_pkt_done;
      unique case ({w_reserve, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      unique case ({r_comp_inc, w_pop})
        2'b10:   r_comp <= r_comp + OCC_W'(1);
        2'b01:   r_comp <= r_comp - OCC_W'(1);
        default: r_comp <= r_comp;
      endcase
    end
  end

  pkt_desc_ring #(
    .DEPTH     (DEPTH),
    .PTR_SZ    (PTR_SZ),
    .PTR_IN_SZ (PTR_IN_SZ)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_reserve),
    .i_wr_len   (PTR_IN_SZ'(w_hdr_len) + PTR_IN_SZ'(1)),
    .i_wr_dest  (w_hdr_dest),
    .i_wptr_inc (w_pkt_done),
    .i_rptr_inc (w_pop),
    .o_wptr     (w_wptr),
    .o_rptr     (w_rptr),
    .o_rd_len   (w_rd_len),
    .o_rd_dest  (w_rd_dest)
  );

  assign bus.in_ready  = w_ready;
  assign bus.write_en  = r_write_en;
  assign bus.waddr     = r_waddr;
  assign bus.waddr_in  = r_waddr_in;
  assign bus.wdata     = r_wdata;
  assign bus.pkt_avail = (r_comp != '0);
  assign bus.rd_entry  = w_rptr;
  assign bus.rd_len    = w_rd_len;
  assign bus.rd_dest   = w_rd_dest;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_pkt_write_ctrl.sv
// Self-checking bench for pkt_write_ctrl: vector table, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_pkt_write_ctrl;

  localparam int DEPTH     = 3;
  localparam int WIDTH     = 11;
  localparam int UWIDTH    = 8;
  localparam int PTR_SZ    = 2;
  localparam int PTR_IN_SZ = 4;
  localparam int NPKT      = 1000;
  localparam int NVEC      = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fails = 0;

  pkt_write_ctrl_if #(.UWIDTH(UWIDTH), .PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ)) bus ();

  pkt_write_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 ready;
    logic                 we;
    logic [PTR_SZ-1:0]    waddr;
    logic [PTR_IN_SZ-1:0] waddr_in;
    logic [7:0]           wdata;
    logic                 avail;
    logic [PTR_SZ-1:0]    rd_entry;
    logic [PTR_IN_SZ-1:0] rd_len;
    logic [3:0]           rd_dest;
    logic                 err;
  } outs_t;

  typedef struct {
    logic v; logic [7:0] d; logic p;
    logic ready; logic we; int wa; int wi; int wd;
    logic avail; int re; int rl; int rdst; logic err;
  } vec_t;

  typedef struct { int entry; int len; int dest; int vis; } desc_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample(output outs_t o);
    o.ready    = bus.in_ready;
    o.we       = bus.write_en;
    o.waddr    = bus.waddr;
    o.waddr_in = bus.waddr_in;
    o.wdata    = bus.wdata;
    o.avail    = bus.pkt_avail;
    o.rd_entry = bus.rd_entry;
    o.rd_len   = bus.rd_len;
    o.rd_dest  = bus.rd_dest;
    o.err      = bus.err;
  endtask

  // Called just after a rising edge; drives one cycle, samples mid-cycle.
  task automatic cycle(input logic v, input logic [7:0] d, input logic p, output outs_t o);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.pkt_pop  = p;
    @(negedge clk);
    sample(o);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.pkt_pop  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input outs_t o, input logic we, input int wa, input int wi, input int wd);
    check({tag, ".write_en"}, o.we, we);
    if (we) begin
      check({tag, ".waddr"}, o.waddr, wa);
      check({tag, ".waddr_in"}, o.waddr_in, wi);
      check({tag, ".wdata"}, o.wdata, wd);
    end
  endtask

  task automatic chk_rd(input string tag, input outs_t o, input logic av, input int re, input int rl, input int rd);
    check({tag, ".pkt_avail"}, o.avail, av);
    if (av) begin
      check({tag, ".rd_entry"}, o.rd_entry, re);
      check({tag, ".rd_len"}, o.rd_len, rl);
      check({tag, ".rd_dest"}, o.rd_dest, rd);
    end
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] hdr, input logic [7:0] base);
    outs_t o;
    cycle(1'b1, hdr, 1'b0, o);
    check({tag, ".hdr_ready"}, o.ready, 1'b1);
    for (int k = 1; k <= int'(hdr[3:0]); k++) begin
      cycle(1'b1, base + 8'(k), 1'b0, o);
      check($sformatf("%s.b%0d_ready", tag, k), o.ready, 1'b1);
    end
  endtask

  task automatic run_table();
    outs_t o;
    vecs[0]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 0, 0, 'h13, 1'b0, 0, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 0, 1, 'hAA, 1'b0, 0, 0, 0, 1'b0};
    vecs[3]  = '{1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 0, 2, 'hBB, 1'b0, 0, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 3, 'hCC, 1'b0, 0, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b1, 0, 4, 1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0,     1'b1, 0, 4, 1, 1'b0};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0};
    vecs[10] = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0};
    vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1, 0, 'h21, 1'b0, 0, 0, 0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1, 1, 'h55, 1'b0, 0, 0, 0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0,     1'b1, 1, 2, 2, 1'b0};
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(vecs[i].v, vecs[i].d, vecs[i].p, o);
      check({tag, ".in_ready"}, o.ready, vecs[i].ready);
      chk_wr(tag, o, vecs[i].we, vecs[i].wa, vecs[i].wi, vecs[i].wd);
      chk_rd(tag, o, vecs[i].avail, vecs[i].re, vecs[i].rl, vecs[i].rdst);
      check({tag, ".err"}, o.err, vecs[i].err);
    end
  endtask

  task automatic seq_full_wrap();
    outs_t o;
    do_reset();
    send_pkt("full.p0", 8'h1A, 8'h00);
    send_pkt("full.p1", 8'h2A, 8'h10);
    send_pkt("full.p2", 8'h3A, 8'h20);
    cycle(1'b1, 8'h4A, 1'b0, o);
    check("full.hdr4_stall0", o.ready, 1'b0);
    chk_wr("full.p2_last", o, 1'b1, 2, 10, 'h2A);
    cycle(1'b1, 8'h4A, 1'b0, o);
    check("full.hdr4_stall1", o.ready, 1'b0);
    chk_rd("full.head", o, 1'b1, 0, 11, 1);
    cycle(1'b1, 8'h4A, 1'b1, o);
    check("full.pop_cycle_ready", o.ready, 1'b0);
    cycle(1'b1, 8'h4A, 1'b0, o);
    check("full.after_pop_ready", o.ready, 1'b1);
    chk_rd("full.after_pop", o, 1'b1, 1, 11, 2);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_wr("full.wrap_hdr", o, 1'b1, 0, 0, 'h4A);
  endtask

  task automatic seq_errors();
    outs_t o;
    do_reset();
    cycle(1'b1, 8'h00, 1'b0, o);
    check("err0.ready", o.ready, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, o);
    check("err0.pulse", o.err, 1'b1);
    chk_wr("err0", o, 1'b0, 0, 0, 0);
    cycle(1'b0, 8'h00, 1'b0, o);
    check("err0.pulse_end", o.err, 1'b0);
    cycle(1'b1, 8'h0C, 1'b0, o);
    check("drop.hdr_ready", o.ready, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 8'(8'h80 + k), 1'b0, o);
      check($sformatf("drop.b%0d_ready", k), o.ready, 1'b1);
      check($sformatf("drop.b%0d_err", k), o.err, (k == 1) ? 1'b1 : 1'b0);
      chk_wr($sformatf("drop.b%0d", k), o, 1'b0, 0, 0, 0);
    end
    cycle(1'b1, 8'h51, 1'b0, o);
    check("drop.next_hdr_ready", o.ready, 1'b1);
    chk_wr("drop.last", o, 1'b0, 0, 0, 0);
    cycle(1'b1, 8'h77, 1'b0, o);
    chk_wr("drop.next_hdr", o, 1'b1, 0, 0, 'h51);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_wr("drop.next_b1", o, 1'b1, 0, 1, 'h77);
    chk_rd("drop.next_pending", o, 1'b0, 0, 0, 0);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_rd("drop.next_avail", o, 1'b1, 0, 2, 5);
  endtask

  task automatic seq_pop_overlap();
    outs_t o;
    do_reset();
    send_pkt("ovl.a", 8'h11, 8'h10);
    send_pkt("ovl.b", 8'h21, 8'h20);
    cycle(1'b0, 8'h00, 1'b0, o);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_rd("ovl.two_stored", o, 1'b1, 0, 2, 1);
    cycle(1'b1, 8'h31, 1'b1, o);
    check("ovl.hdr_pop_ready", o.ready, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, o);
    chk_rd("ovl.rd_advanced", o, 1'b1, 1, 2, 2);
    cycle(1'b1, 8'h41, 1'b0, o);
    check("ovl.occ2_hdr_ready", o.ready, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, o);
    cycle(1'b1, 8'h51, 1'b0, o);
    check("ovl.occ3_stall", o.ready, 1'b0);
    do_reset();
    send_pkt("cmp.a", 8'h11, 8'h10);
    cycle(1'b0, 8'h00, 1'b0, o);
    cycle(1'b0, 8'h00, 1'b0, o);
    send_pkt("cmp.b", 8'h21, 8'h20);
    cycle(1'b0, 8'h00, 1'b1, o);
    chk_rd("cmp.pop_a", o, 1'b1, 0, 2, 1);
    cycle(1'b0, 8'h00, 1'b1, o);
    chk_rd("cmp.b_visible", o, 1'b1, 1, 2, 2);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_rd("cmp.empty", o, 1'b0, 0, 0, 0);
  endtask

  task automatic seq_reset_mid();
    outs_t o;
    do_reset();
    send_pkt("rst.a", 8'h72, 8'h30);
    cycle(1'b0, 8'h00, 1'b0, o);
    cycle(1'b0, 8'h00, 1'b0, o);
    cycle(1'b1, 8'h6A, 1'b0, o);
    for (int k = 1; k <= 5; k++) cycle(1'b1, 8'(8'h40 + k), 1'b0, o);
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    sample(o);
    check("rst.in_ready", o.ready, 1'b0);
    check("rst.write_en", o.we, 1'b0);
    check("rst.waddr", o.waddr, 0);
    check("rst.waddr_in", o.waddr_in, 0);
    check("rst.wdata", o.wdata, 0);
    check("rst.pkt_avail", o.avail, 1'b0);
    check("rst.rd_entry", o.rd_entry, 0);
    check("rst.rd_len", o.rd_len, 0);
    check("rst.rd_dest", o.rd_dest, 0);
    check("rst.err", o.err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h81, 1'b0, o);
    check("rst.fresh_ready", o.ready, 1'b1);
    chk_rd("rst.fresh_hdr", o, 1'b0, 0, 0, 0);
    cycle(1'b1, 8'h99, 1'b0, o);
    chk_wr("rst.fresh_hdr", o, 1'b1, 0, 0, 'h81);
    chk_rd("rst.fresh_b1", o, 1'b0, 0, 0, 0);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_wr("rst.fresh_b1", o, 1'b1, 0, 1, 'h99);
    chk_rd("rst.fresh_wr", o, 1'b0, 0, 0, 0);
    cycle(1'b0, 8'h00, 1'b0, o);
    chk_rd("rst.fresh_done", o, 1'b1, 0, 2, 8);
  endtask

  // Packet-level reference: entries are reserved by a legal header, completed
  // descriptors become readable two cycles after their last byte.
  task automatic run_random();
    outs_t      o;
    logic [7:0] stream [$];
    desc_t      descq [$];
    int         pkts = 0, cyc = 0;
    int         m_occ = 0, m_wp = 0, m_rem = 0, m_idx = 0, m_len = 0, m_dest = 0;
    bit         m_drop = 0;
    bit         p_we = 0, p_err = 0;
    int         p_wa = 0, p_wi = 0, p_wd = 0;
    do_reset();
    while ((pkts < NPKT || stream.size() != 0) && cyc < 50000) begin
      bit e_ready, e_avail, v, p, acc;
      logic [7:0] d;
      string tag;
      if (stream.size() == 0 && pkts < NPKT) begin
        int r, l;
        r = $urandom_range(99);
        if (r < 5)       l = 0;
        else if (r < 10) l = $urandom_range(15, 11);
        else             l = $urandom_range(WIDTH - 1, 1);
        stream.push_back({4'($urandom_range(15)), 4'(l)});
        for (int k = 0; k < l; k++) stream.push_back(8'($urandom));
        pkts++;
      end
      e_ready = (m_rem > 0) || (m_occ < DEPTH);
      e_avail = (descq.size() > 0) && (descq[0].vis <= cyc);
      v = (stream.size() > 0) && ($urandom_range(3) != 0);
      d = v ? stream[0] : 8'($urandom);
      p = ($urandom_range(99) < 35);
      cycle(v, d, p, o);
      tag = $sformatf("rnd.c%0d", cyc);
      check({tag, ".in_ready"}, o.ready, e_ready);
      chk_wr(tag, o, p_we, p_wa, p_wi, p_wd);
      if (e_avail) chk_rd(tag, o, 1'b1, descq[0].entry, descq[0].len, descq[0].dest);
      else         chk_rd(tag, o, 1'b0, 0, 0, 0);
      check({tag, ".err"}, o.err, p_err);
      acc   = v && e_ready;
      p_we  = 0;
      p_err = 0;
      if (acc) begin
        int l;
        void'(stream.pop_front());
        l = int'(d[3:0]);
        if (m_rem == 0) begin
          if (l == 0) p_err = 1;
          else if (l > WIDTH - 1) begin
            p_err = 1; m_rem = l; m_drop = 1;
          end else begin
            m_rem = l; m_drop = 0; m_idx = 1; m_len = l + 1; m_dest = int'(d[7:4]);
            m_occ++;
            p_we = 1; p_wa = m_wp; p_wi = 0; p_wd = int'(d);
          end
        end else begin
          if (!m_drop) begin
            p_we = 1; p_wa = m_wp; p_wi = m_idx; p_wd = int'(d);
            m_idx++;
          end
          m_rem--;
          if (m_rem == 0 && !m_drop) begin
            descq.push_back('{m_wp, m_len, m_dest, cyc + 2});
            m_wp = (m_wp + 1) % DEPTH;
          end
        end
      end
      if (p && e_avail) begin
        void'(descq.pop_front());
        m_occ--;
      end
      cyc++;
    end
    check("rnd.all_packets_sent", (pkts >= NPKT && stream.size() == 0), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t o;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.pkt_pop  = 1'b0;
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, o);
    check("reset.in_ready", o.ready, 1'b1);
    chk_wr("reset", o, 1'b0, 0, 0, 0);
    check("reset.waddr", o.waddr, 0);
    check("reset.waddr_in", o.waddr_in, 0);
    check("reset.wdata", o.wdata, 0);
    check("reset.pkt_avail", o.avail, 1'b0);
    check("reset.rd_entry", o.rd_entry, 0);
    check("reset.rd_len", o.rd_len, 0);
    check("reset.rd_dest", o.rd_dest, 0);
    check("reset.err", o.err, 1'b0);
    run_table();
    seq_full_wrap();
    seq_errors();
    seq_pop_overlap();
    seq_reset_mid();
    run_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/pkt_write_ctrl.md
# pkt_write_ctrl

Ingress write controller for one router input port. It accepts a byte stream under valid/ready, parses the packet header and writes each packet into one entry of the port's FIFO memory through its `write_en`/`waddr`/`waddr_in`/`wdata` write port. It also tracks entry occupancy and publishes a descriptor for the oldest complete packet to the downstream read/arbitration stage, which releases entries with `pkt_pop`.

## Interface
- `DEPTH`, 3: number of FIFO entries (packets); any value ≥ 2, non-power-of-2 allowed
- `WIDTH`, 11: bytes per entry; the maximum packet is 1 header byte plus `WIDTH-1` payload bytes
- `UWIDTH`, 8: byte width in bits
- `PTR_SZ`, 2: entry index width, ≥ ceil(log2(DEPTH))
- `PTR_IN_SZ`, 4: byte-in-entry index width, ≥ ceil(log2(WIDTH))

Ports:
- `clk` in 1: single clock; all state changes on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: input byte valid
- `in_data` in UWIDTH: input byte
- `in_ready` out 1: controller accepts `in_data` this cycle
- `write_en` out 1: memory write strobe, registered
- `waddr` out PTR_SZ: entry index, registered
- `waddr_in` out PTR_IN_SZ: byte index within the entry, registered
- `wdata` out UWIDTH: write byte, registered
- `pkt_avail` out 1: at least one complete packet is stored
- `rd_entry` out PTR_SZ: entry index of the oldest complete packet
- `rd_len` out PTR_IN_SZ: total bytes of that packet (L+1)
- `rd_dest` out 4: destination field of that packet
- `pkt_pop` in 1: reader is finished with entry `rd_entry`; ignored when `pkt_avail`=0
- `err` out 1: one-cycle pulse on a malformed header

## Operation
- Header byte: bits[3:0] = payload length L; bits[7:4] = destination. A legal packet has 1 ≤ L ≤ WIDTH-1.
- A byte is accepted when `in_valid && in_ready`.
- State machine:
  - IDLE: waits for a header. `in_ready` = (occ < DEPTH).
  - A legal header moves IDLE→PAYLOAD. The entry at `wptr` is reserved (occ+1), the header is written at byte 0, and L and dest are stored in the descriptor for that entry.
  - An illegal header (L = 0 or L > WIDTH-1) pulses `err` and is not written.
    - L = 0: stay in IDLE.
    - L > WIDTH-1: go to DROP with drop count L.
  - PAYLOAD: `in_ready`=1. Byte k (k = 1..L) is written at `waddr_in`=k. After byte L: `wptr` advances, the complete count increments, and the state returns to IDLE.
  - DROP: `in_ready`=1. L bytes are accepted and discarded with no writes, then the state returns to IDLE.
- `wptr` and `rptr` wrap from DEPTH-1 to 0 by explicit compare, never by modulo-2^PTR_SZ overflow.
- occ counts reserved entries (filling plus complete), range 0..DEPTH. comp counts complete entries, range 0..occ.
- `pkt_pop` with `pkt_avail`=1 advances `rptr` and decrements both occ and comp.
- Simultaneous header reservation and pop: occ is unchanged. Simultaneous completion and pop: comp is unchanged.
- `pkt_avail` = (comp ≠ 0). `rd_entry` = `rptr`. `rd_len` and `rd_dest` come from the descriptor at `rptr`.
- A full FIFO (occ = DEPTH) stalls only at a header boundary. A packet already in PAYLOAD always completes, because its entry is reserved.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE; `wptr`, `rptr`, occ and comp = 0.
  - `write_en`, `waddr`, `waddr_in`, `wdata`, `pkt_avail`, `rd_entry`, `rd_len`, `rd_dest`, `err` = 0.
  - `in_ready` = 0 while `rst_n` is low.
- Reset mid-packet discards the partial packet and all stored packets.
- A byte accepted in cycle t is written to memory in cycle t+1 (`write_en`=1 with its address and data).
- Last payload byte accepted in cycle t: `pkt_avail`/comp update is visible in cycle t+2, so the reader never sees an unwritten byte.
- `err` is asserted in cycle t+1 after the bad header is accepted.
- A pop in cycle t frees the entry in cycle t+1. A header arriving in cycle t while occ = DEPTH is not accepted in cycle t.
- Throughput is one byte per cycle. Back-to-back packets need no idle cycle between the last payload byte and the next header.

## Structure
- Shared package `router_pkg`:
  - header field positions (`LEN_LSB`/`LEN_MSB`, `DEST_LSB`/`DEST_MSB`)
  - state encoding enum (IDLE, PAYLOAD, DROP)
  - `MAX_LEN` = WIDTH-1
- One sub-module, `pkt_desc_ring`: DEPTH-entry register array of {len, dest} with write at `wptr` and read at `rptr`, plus the wrap-aware pointer-increment logic. The FSM, counters and registered write port stay in `pkt_write_ctrl`.

## Test plan
- Single packet 0x13,0xAA,0xBB,0xCC after reset:
  - writes (0,0,0x13), (0,1,0xAA), (0,2,0xBB), (0,3,0xCC) on consecutive cycles
  - `pkt_avail`=1 two cycles after 0xCC, with `rd_entry`=0, `rd_len`=4, `rd_dest`=1
- Three max-length packets (L=10) back-to-back with no pops:
  - the fourth header sees `in_ready`=0
  - a pop in cycle t lets the header be accepted in cycle t+1 and written to entry 0 (wrap)
- Header 0x00 → `err` pulse, no write, state stays IDLE. Header 0x0C followed by 12 bytes → `err` pulse, no writes; the following legal packet is stored in entry 0.
- Pop in the same cycle as a new header at occ=2 → occ stays 2 and `rd_entry` advances. Pop in the same cycle as a packet completion → comp unchanged.
- Reset asserted after 5 of 10 payload bytes → all outputs 0 immediately. After release, a fresh packet goes to entry 0 with `pkt_avail`=0 until it is complete.
- Random `in_valid` gaps and random pops over 1000 packets → scoreboard matches every written byte and descriptor; occ never exceeds DEPTH.
